// File: rtl/coin_session_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : coin_session_ctrl_pkg
// Description : Shared state encoding, session modes and default pricing.
// Revision    : 1.0 - initial release
// ============================================================================
package coin_session_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_RUN    = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] c_MODE_SHORT = 4'd1;
    localparam logic [3:0] c_MODE_LONG  = 4'd9;

    localparam int c_DEBOUNCE_CYCLES_DEF = 4;
    localparam int c_PRICE_SHORT_DEF     = 1;
    localparam int c_PRICE_LONG_DEF      = 3;
    localparam int c_CREDIT_MAX_DEF      = 9;

endpackage
`default_nettype wire

// File: rtl/coin_session_ctrl_debounce.sv
`default_nettype none
// ============================================================================
// Module      : coin_debounce
// Description : 2-flop synchronizer plus counting debouncer; pulses on each
//               accepted rising edge of the filtered coin level.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_debounce
    import coin_session_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF
) (
    input  logic Clk,
    input  logic Reset,
    input  logic i_coinRaw,
    output logic o_rise
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_rise;
    logic [c_CNT_W-1:0] r_cnt;

    // The level flips on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_coinRaw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_level <= r_sync2;
                r_rise  <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/coin_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : coin_session_ctrl
// Description : Coin-operated session controller: credit bookkeeping, plan
//               purchase and session counter handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module coin_session_ctrl
    import coin_session_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int PRICE_SHORT     = c_PRICE_SHORT_DEF,
    parameter int PRICE_LONG      = c_PRICE_LONG_DEF,
    parameter int CREDIT_MAX      = c_CREDIT_MAX_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       CoinIn,
    input  logic       Start,
    input  logic [3:0] ModeSel,
    input  logic       TimeUp,
    output logic       CounterEnable,
    output logic [3:0] CounterInput,
    output logic [3:0] Credit,
    output logic       CoinAccepted,
    output logic       CoinReject,
    output logic       SessionDone
);

    localparam logic [3:0] c_PRICE_S    = 4'(PRICE_SHORT);
    localparam logic [3:0] c_PRICE_L    = 4'(PRICE_LONG);
    localparam logic [3:0] c_CREDIT_MAX = 4'(CREDIT_MAX);

    state_e     r_state;
    logic [3:0] r_credit;
    logic [3:0] r_counterInput;
    logic       r_counterEnable;
    logic       r_coinAccepted;
    logic       r_coinReject;
    logic       r_sessionDone;

    logic       w_coin;
    logic [3:0] w_price;
    logic       w_startOk;
    logic [3:0] w_base;
    logic       w_accept;
    logic       w_reject;
    logic [3:0] w_creditNext;

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_coinRaw(CoinIn),
        .o_rise   (w_coin)
    );

    // Price is checked against pre-cycle credit; a coparallel coin lands on top.
    always_comb begin
        w_price      = (ModeSel == c_MODE_SHORT) ? c_PRICE_S : c_PRICE_L;
        w_startOk    = (r_state == ST_CREDIT) && Start && (r_credit >= w_price);
        w_base       = w_startOk ? (r_credit - w_price) : r_credit;
        w_accept     = w_coin && (w_base < c_CREDIT_MAX);
        w_reject     = w_coin && !w_accept;
        w_creditNext = w_accept ? (w_base + 4'd1) : w_base;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state         <= ST_IDLE;
            r_credit        <= 4'd0;
            r_counterInput  <= 4'd0;
            r_counterEnable <= 1'b0;
            r_coinAccepted  <= 1'b0;
            r_coinReject    <= 1'b0;
            r_sessionDone   <= 1'b0;
        end else begin
            r_credit       <= w_creditNext;
            r_coinAccepted <= w_accept;
            r_coinReject   <= w_reject;
            r_sessionDone  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) r_state <= ST_CREDIT;
                end
                ST_CREDIT: begin
                    if (w_startOk) begin
                        r_state         <= ST_RUN;
                        r_counterInput  <= (ModeSel == c_MODE_SHORT) ? c_MODE_SHORT : c_MODE_LONG;
                        r_counterEnable <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (TimeUp) begin
                        r_state         <= ST_DONE;
                        r_counterEnable <= 1'b0;
                        r_sessionDone   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= (w_creditNext != 4'd0) ? ST_CREDIT : ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign CounterEnable = r_counterEnable;
    assign CounterInput  = r_counterInput;
    assign Credit        = r_credit;
    assign CoinAccepted  = r_coinAccepted;
    assign CoinReject    = r_coinReject;
    assign SessionDone   = r_sessionDone;

endmodule
`default_nettype wire

// File: tb/tb_coin_session_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_coin_session_ctrl
// Description : Directed scoreboard bench for coin_session_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coin_session_ctrl;

    localparam int c_ACC  = 0;
    localparam int c_REJ  = 1;
    localparam int c_DONE = 2;

    typedef struct {
        int         kind;
        logic [3:0] credit;
        logic       en;
    } exp_t;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       CoinIn;
    logic       Start;
    logic [3:0] ModeSel;
    logic       TimeUp;
    logic       CounterEnable;
    logic [3:0] CounterInput;
    logic [3:0] Credit;
    logic       CoinAccepted;
    logic       CoinReject;
    logic       SessionDone;

    exp_t q[$];
    int   nVec = 0;
    int   nMis = 0;

    coin_session_ctrl dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .CoinIn       (CoinIn),
        .Start        (Start),
        .ModeSel      (ModeSel),
        .TimeUp       (TimeUp),
        .CounterEnable(CounterEnable),
        .CounterInput (CounterInput),
        .Credit       (Credit),
        .CoinAccepted (CoinAccepted),
        .CoinReject   (CoinReject),
        .SessionDone  (SessionDone)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pushExp(input int kind, input int credit, input logic en);
        exp_t e;
        e.kind   = kind;
        e.credit = 4'(credit);
        e.en     = en;
        q.push_back(e);
    endtask

    task automatic insertCoin();
        CoinIn = 1'b1;
        repeat (10) tick();
        CoinIn = 1'b0;
        repeat (10) tick();
    endtask

    task automatic doReset();
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        tick();
    endtask

    // Monitor: every output pulse must match the next queued expectation.
    always @(negedge Clk) begin
        if (!Reset && (CoinAccepted || CoinReject || SessionDone)) begin
            int   actKind;
            exp_t e;
            actKind = SessionDone ? c_DONE : (CoinReject ? c_REJ : c_ACC);
            if (CoinAccepted && CoinReject) check("accept_and_reject_together", 1, 0);
            if (q.size() == 0) begin
                check("unexpected_event_kind", actKind, -1);
            end else begin
                e = q.pop_front();
                check("event_kind", actKind, e.kind);
                check("event_credit", int'(Credit), int'(e.credit));
                check("event_enable", int'(CounterEnable), int'(e.en));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        Reset = 1'b1; CoinIn = 1'b0; Start = 1'b0; ModeSel = 4'd0; TimeUp = 1'b0;
        doReset();
        check("reset_credit", int'(Credit), 0);
        check("reset_enable", int'(CounterEnable), 0);
        check("reset_counter_input", int'(CounterInput), 0);
        check("reset_pulses", int'({CoinAccepted, CoinReject, SessionDone}), 0);

        // Short glitch is filtered, clean pulse counts once
        CoinIn = 1'b1;
        repeat (3) tick();
        CoinIn = 1'b0;
        repeat (10) tick();
        pushExp(c_ACC, 1, 1'b0);
        insertCoin();
        check("glitch_then_coin_credit", int'(Credit), 1);

        // Long plan with one coin is refused
        ModeSel = 4'd9;
        Start = 1'b1; tick(); Start = 1'b0;
        tick();
        check("poor_start_enable", int'(CounterEnable), 0);
        check("poor_start_credit", int'(Credit), 1);
        pushExp(c_ACC, 2, 1'b0); insertCoin();
        pushExp(c_ACC, 3, 1'b0); insertCoin();
        Start = 1'b1; tick(); Start = 1'b0;
        check("long_start_enable", int'(CounterEnable), 1);
        check("long_start_counter_input", int'(CounterInput), 9);
        check("long_start_credit", int'(Credit), 0);

        // Mode change and start in RUN are ignored
        ModeSel = 4'd1;
        repeat (3) tick();
        Start = 1'b1; tick(); Start = 1'b0;
        check("run_counter_input_held", int'(CounterInput), 9);
        pushExp(c_DONE, 0, 1'b0);
        TimeUp = 1'b1; tick(); TimeUp = 1'b0;
        check("done_enable_off", int'(CounterEnable), 0);
        tick();
        check("done_single_cycle", int'(SessionDone), 0);
        check("after_done_counter_input", int'(CounterInput), 9);
        check("after_done_credit", int'(Credit), 0);
        TimeUp = 1'b1; tick(); TimeUp = 1'b0;
        tick();

        // Ten coins: saturate at nine, tenth is rejected
        for (int i = 1; i <= 9; i++) begin
            pushExp(c_ACC, i, 1'b0);
            insertCoin();
        end
        pushExp(c_REJ, 9, 1'b0);
        insertCoin();
        check("saturated_credit", int'(Credit), 9);

        doReset();
        check("reset_clears_credit", int'(Credit), 0);
        pushExp(c_ACC, 1, 1'b0);
        insertCoin();

        // Start coincides with the coin event: credit 1 - 1 + 1
        ModeSel = 4'd1;
        pushExp(c_ACC, 1, 1'b1);
        CoinIn = 1'b1;
        repeat (6) tick();
        Start = 1'b1; tick(); Start = 1'b0;
        check("same_cycle_enable", int'(CounterEnable), 1);
        check("same_cycle_counter_input", int'(CounterInput), 1);
        check("same_cycle_credit", int'(Credit), 1);
        repeat (3) tick();
        CoinIn = 1'b0;
        repeat (10) tick();

        // Coins accumulate in RUN, then reset mid-session
        for (int i = 2; i <= 4; i++) begin
            pushExp(c_ACC, i, 1'b1);
            insertCoin();
        end
        check("run_credit", int'(Credit), 4);
        Reset = 1'b1; tick();
        check("midrun_reset_outputs",
              int'({CounterEnable, CounterInput, Credit, CoinAccepted, CoinReject, SessionDone}), 0);
        Reset = 1'b0;
        repeat (5) tick();
        check("post_reset_no_done", int'({SessionDone, CounterEnable, Credit}), 0);

        // Coin held high across reset release counts once
        CoinIn = 1'b1;
        Reset = 1'b1; repeat (2) tick(); Reset = 1'b0;
        pushExp(c_ACC, 1, 1'b0);
        repeat (12) tick();
        CoinIn = 1'b0;
        repeat (12) tick();
        check("held_through_reset_credit", int'(Credit), 1);

        repeat (5) tick();
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
`default_nettype wire
